// File: rtl/game_board_pkg.sv
// game_board shared definitions: sizes, sentinels, opcodes,
// controller states and the BCD display formatter.
package game_board_pkg;

    localparam int VAL_W = 10;
    localparam int NSLOT = 4;
    localparam int PROD_W = 2 * VAL_W;

    localparam logic [2:0] SEL_NONE = 3'b111;
    localparam logic [3:0] BLANK = 4'hF;
    localparam logic [11:0] FIELD_BLANK = {3{BLANK}};

    localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(999);
    localparam logic [VAL_W-1:0] TARGET = VAL_W'(24);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PICK1,
        ST_PICK2,
        ST_PICKOP,
        ST_CALC,
        ST_CONV,
        ST_DONE
    } state_e;

    // Blank leading zeros; the units digit is always shown.
    function automatic logic [11:0] fmt_bcd(input logic [11:0] bcd);
        logic [3:0] h;
        logic [3:0] t;
        h = bcd[11:8];
        t = bcd[7:4];
        if (h == 4'd0) begin
            h = BLANK;
            if (t == 4'd0) begin
                t = BLANK;
            end
        end
        return {h, t, bcd[3:0]};
    endfunction

endpackage

// File: rtl/game_board_bin2bcd.sv
// Sequential double-dabble converter: one bit per cycle,
// done pulses VAL_W+1 cycles after start with bcd valid.
module game_board_bin2bcd
    import game_board_pkg::*;
(
    input  logic             clk_100m,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             done,
    output logic [11:0]      bcd
);

    logic [VAL_W-1:0] sh_q, sh_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [11:0]      adj;

    // Add-3 correction per digit, then shift one bit in.
    always_comb begin
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        adj    = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        if (clr) begin
            run_d = 1'b0;
            cnt_d = 4'd0;
        end else if (start) begin
            sh_d  = bin;
            bcd_d = 12'd0;
            cnt_d = 4'(VAL_W);
            run_d = 1'b1;
        end else if (run_q) begin
            {bcd_d, sh_d} = {adj[10:0], sh_q, 1'b0};
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Converter state registers.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/game_board.sv
// 24-game board state: four slots, selection/operator FSM,
// arithmetic on the chosen pair and the BCD display bus.
module game_board
    import game_board_pkg::*;
(
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        new_game,
    input  logic [15:0] deal_vals,
    input  logic        sel_valid,
    input  logic [1:0]  sel_idx,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic        cancel,
    output logic [47:0] numbers_concat,
    output logic [2:0]  s1,
    output logic [2:0]  s2,
    output logic        busy,
    output logic        error,
    output logic        win,
    output logic        lose
);

    state_e           state_q, state_d;
    logic [VAL_W-1:0] sval_q [NSLOT];
    logic [VAL_W-1:0] sval_d [NSLOT];
    logic [11:0]      fld_q [NSLOT];
    logic [11:0]      fld_d [NSLOT];
    logic [NSLOT-1:0] svld_q, svld_d;
    logic [2:0]       s1_q, s1_d;
    logic [2:0]       s2_q, s2_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       ld_q, ld_d;
    logic             crun_q, crun_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic             err_q, err_d;

    logic             cv_clr;
    logic             cv_start;
    logic [VAL_W-1:0] cv_bin;
    logic             cv_done;
    logic [11:0]      cv_bcd;

    logic [VAL_W-1:0]  a, b;
    logic [PROD_W-1:0] res;
    logic              calc_ok;
    logic              deal_bad;
    logic [2:0]        nleft;

    game_board_bin2bcd u_conv (
        .clk_100m (clk_100m),
        .rst      (rst),
        .clr      (cv_clr),
        .start    (cv_start),
        .bin      (cv_bin),
        .done     (cv_done),
        .bcd      (cv_bcd)
    );

    // Arithmetic on the selected pair and its legality check.
    always_comb begin
        a       = sval_q[s1_q[1:0]];
        b       = sval_q[s2_q[1:0]];
        res     = '0;
        calc_ok = 1'b1;
        unique case (op_q)
            OP_ADD: res = PROD_W'(a) + PROD_W'(b);
            OP_SUB: begin
                calc_ok = (a >= b);
                res     = PROD_W'(a - b);
            end
            OP_MUL: res = PROD_W'(a) * PROD_W'(b);
            OP_DIV: begin
                if (b == '0) begin
                    calc_ok = 1'b0;
                end else begin
                    calc_ok = ((a % b) == '0);
                    res     = PROD_W'(a / b);
                end
            end
        endcase
        if (res > PROD_W'(MAX_VAL)) begin
            calc_ok = 1'b0;
        end
    end

    // Deal legality and count of occupied slots.
    always_comb begin
        deal_bad = 1'b0;
        nleft    = 3'd0;
        for (int i = 0; i < NSLOT; i++) begin
            if (deal_vals[(NSLOT-1-i)*4 +: 4] == 4'd0 ||
                deal_vals[(NSLOT-1-i)*4 +: 4] > 4'd13) begin
                deal_bad = 1'b1;
            end
            nleft = nleft + 3'(svld_q[i]);
        end
    end

    // Controller next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        sval_d   = sval_q;
        fld_d    = fld_q;
        svld_d   = svld_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        op_d     = op_q;
        ld_d     = ld_q;
        crun_d   = crun_q;
        win_d    = win_q;
        lose_d   = lose_q;
        err_d    = 1'b0;
        cv_clr   = 1'b0;
        cv_start = 1'b0;
        cv_bin   = sval_q[ld_q];
        if (new_game) begin
            cv_clr = 1'b1;
            s1_d   = SEL_NONE;
            s2_d   = SEL_NONE;
            win_d  = 1'b0;
            lose_d = 1'b0;
            crun_d = 1'b0;
            ld_d   = 2'd0;
            fld_d  = '{default: FIELD_BLANK};
            if (deal_bad) begin
                err_d   = 1'b1;
                svld_d  = '0;
                sval_d  = '{default: '0};
                state_d = ST_IDLE;
            end else begin
                svld_d = '1;
                for (int i = 0; i < NSLOT; i++) begin
                    sval_d[i] = VAL_W'(deal_vals[(NSLOT-1-i)*4 +: 4]);
                end
                state_d = ST_LOAD;
            end
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: ;
                ST_LOAD: begin
                    if (!crun_q) begin
                        cv_start = 1'b1;
                        crun_d   = 1'b1;
                    end else if (cv_done) begin
                        fld_d[ld_q] = fmt_bcd(cv_bcd);
                        crun_d      = 1'b0;
                        if (ld_q == 2'(NSLOT - 1)) begin
                            state_d = ST_PICK1;
                        end else begin
                            ld_d = ld_q + 2'd1;
                        end
                    end
                end
                ST_PICK1: begin
                    if (sel_valid && svld_q[sel_idx]) begin
                        s1_d    = {1'b0, sel_idx};
                        state_d = ST_PICK2;
                    end
                end
                ST_PICK2: begin
                    if (cancel) begin
                        s1_d    = SEL_NONE;
                        s2_d    = SEL_NONE;
                        state_d = ST_PICK1;
                    end else if (sel_valid && sel_idx == s1_q[1:0]) begin
                        s1_d    = SEL_NONE;
                        state_d = ST_PICK1;
                    end else if (sel_valid && svld_q[sel_idx]) begin
                        s2_d    = {1'b0, sel_idx};
                        state_d = ST_PICKOP;
                    end
                end
                ST_PICKOP: begin
                    if (cancel) begin
                        s1_d    = SEL_NONE;
                        s2_d    = SEL_NONE;
                        state_d = ST_PICK1;
                    end else if (op_valid) begin
                        op_d    = op;
                        state_d = ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (!calc_ok) begin
                        err_d   = 1'b1;
                        s1_d    = SEL_NONE;
                        s2_d    = SEL_NONE;
                        state_d = ST_PICK1;
                    end else begin
                        sval_d[s1_q[1:0]] = res[VAL_W-1:0];
                        sval_d[s2_q[1:0]] = '0;
                        svld_d[s2_q[1:0]] = 1'b0;
                        fld_d[s2_q[1:0]]  = FIELD_BLANK;
                        cv_start = 1'b1;
                        cv_bin   = res[VAL_W-1:0];
                        state_d  = ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (cv_done) begin
                        fld_d[s1_q[1:0]] = fmt_bcd(cv_bcd);
                        s1_d = SEL_NONE;
                        s2_d = SEL_NONE;
                        if (nleft == 3'd1) begin
                            win_d   = (sval_q[s1_q[1:0]] == TARGET);
                            lose_d  = (sval_q[s1_q[1:0]] != TARGET);
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_PICK1;
                        end
                    end
                end
            endcase
        end
    end

    // Board state registers.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sval_q  <= '{default: '0};
            fld_q   <= '{default: FIELD_BLANK};
            svld_q  <= '0;
            s1_q    <= SEL_NONE;
            s2_q    <= SEL_NONE;
            op_q    <= OP_ADD;
            ld_q    <= 2'd0;
            crun_q  <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sval_q  <= sval_d;
            fld_q   <= fld_d;
            svld_q  <= svld_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            op_q    <= op_d;
            ld_q    <= ld_d;
            crun_q  <= crun_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            err_q   <= err_d;
        end
    end

    // Display bus: slot 0 in the top field.
    always_comb begin
        numbers_concat = '0;
        for (int i = 0; i < NSLOT; i++) begin
            numbers_concat[(NSLOT-1-i)*12 +: 12] = fld_q[i];
        end
    end

    assign s1    = s1_q;
    assign s2    = s2_q;
    assign busy  = (state_q == ST_LOAD) || (state_q == ST_CALC) ||
                   (state_q == ST_CONV);
    assign error = err_q;
    assign win   = win_q;
    assign lose  = lose_q;

endmodule

// File: doc/game_board.md
Name: game_board

Overview:
- Upstream stage of the VGA display path; holds the live 24-game state.
- Stores four number slots and tracks the player's two selections and chosen operator.
- Applies integer arithmetic to the selected pair and produces the 48-bit BCD digit bus plus the s1/s2 highlight indices the display consumes.
- Binary-to-BCD conversion is sequential; the display bus updates only after a conversion completes.

Parameters:
VAL_W, 10, binary width of a slot value (max legal value 999)
NSLOT, 4, number of slots (fixed; 3 BCD digits per slot gives 48 bits)

Ports:
clk_100m  input  1  system clock
rst  input  1  synchronous, active-high reset
new_game  input  1  pulse: load deal_vals as a new hand
deal_vals  input  16  four 4-bit card values; slot0 in [15:12]; legal range 1..13
sel_valid  input  1  pulse: player selects slot sel_idx
sel_idx  input  2  slot index
op_valid  input  1  pulse: apply operator op to the selected pair
op  input  2  0 add, 1 sub, 2 mul, 3 div
cancel  input  1  pulse: clear both selections
numbers_concat  output  48  slot0 in [47:36], hundreds digit in the high nibble; 4'hF = blank
s1  output  3  first selection, 0..3; 3'b111 = none
s2  output  3  second selection, 0..3; 3'b111 = none
busy  output  1  high in LOAD, CALC and CONV
error  output  1  one-cycle pulse on a rejected load or operation
win  output  1  level: single remaining value equals 24
lose  output  1  level: single remaining value is not 24

Behaviour:
- Reset values:
  - all slots empty
  - numbers_concat = 48'hFFFF_FFFF_FFFF
  - s1 = s2 = 3'b111
  - busy, error, win and lose all 0
  - state IDLE
- States: IDLE, LOAD, PICK1, PICK2, PICKOP, CALC, CONV, DONE.
- new_game:
  - Accepted in every state; overrides all other inputs in the same cycle.
  - Aborts any in-flight conversion by pulsing the converter's clr input.
  - Clears s1/s2, win and lose.
  - If any deal nibble is 0 or >13: error pulse, slots cleared, go to IDLE.
  - Otherwise: go to LOAD, then convert slots 0..3 in order; each slot's 12-bit field is written when its conversion completes; then go to PICK1.
- PICK1:
  - sel_valid on a non-empty slot: s1 = sel_idx, go to PICK2.
  - Empty slot: ignored.
- PICK2:
  - sel_valid on s1's slot: s1 = 7, back to PICK1.
  - Other non-empty slot: s2 = sel_idx, go to PICKOP.
  - Empty slot: ignored.
- PICKOP: op_valid captures op and moves to CALC.
- cancel: in PICK2 or PICKOP sets s1 = s2 = 7 and returns to PICK1; ignored elsewhere.
- CALC (1 cycle): computes a = slot[s1], b = slot[s2].
  - Reject when: sub with a<b; div with b==0 or a%b!=0; any result >999.
  - Reject: error pulse, slots unchanged, s1 = s2 = 7, go to PICK1.
  - Accept: slot[s1] = result; slot[s2] becomes empty and its field = 12'hFFF; start a conversion of slot[s1]; go to CONV.
- CONV: on converter done:
  - write the slot[s1] field, set s1 = s2 = 7;
  - if exactly one slot remains: go to DONE, with win = (value==24) and lose = !win;
  - otherwise go to PICK1.
- sel_valid, op_valid and cancel are ignored while busy and in DONE/IDLE.
- Digit formatting: leading-zero hundreds and tens digits are shown as 4'hF; the units digit is always shown (value 5 → 12'hFF5, value 24 → 12'hF24, value 105 → 12'h105).
- Converter latency: done pulses exactly VAL_W+1 cycles after the start cycle; bcd is valid in the done cycle.
- Multiply uses a 2*VAL_W-bit product before the range check, so no wrap-around is possible.

Decomposition:
- Shared package: slot count, VAL_W, SEL_NONE = 3'b111, BLANK = 4'hF, opcode constants, state enum.
- Sub-module bin2bcd:
  - sequential double-dabble, VAL_W cycles;
  - ports clk_100m, rst, clr, start, bin, done, bcd[11:0].

Test Plan:
- Reset, then idle 5 cycles -> numbers_concat = 48'hFFFFFFFFFFFF, s1 = s2 = 7, busy = 0.
- Load deal_vals = 16'h1234 -> after 4×(VAL_W+1) cycles plus overhead, numbers_concat = 48'hFF1FF2FF3FF4, state PICK1.
- Win sequence from 1234:
  - sel 0, sel 1, add -> slot0 = 3, numbers_concat = 48'hFF3FFFFF3FF4;
  - then 0+2 add, then 0*3 mul -> numbers_concat = 48'hF24FFFFFFFFF, win = 1, lose = 0.
- Rejects on deal 16'h7253:
  - sel 0, sel 1, div (7/2) -> error pulse, slots unchanged;
  - sel 1, sel 3, sub (2-3) -> error pulse, slots unchanged.
- Deal 16'hDDDD (13 each): mul → 169 shown 12'h169; then 169*13 = 2197 -> error pulse, slots unchanged.
- new_game asserted mid-CONV -> conversion aborted, new hand loaded cleanly; same-slot reselect in PICK2 clears s1 to 7; deal with nibble 0 -> error pulse, state IDLE.
